// File: rtl/ofdm_bin_slicer.sv
// Slices each FFT bin to a level from |I|+|Q| against ascending thresholds and packs data-bin levels into OUT_W-bit words.
// Latency: word on out_valid one cycle after the accept that completes it; sym_done/pilot_ok/len_err one cycle after the closing accept.
// Backpressure: single output register; in_ready = !out_valid || out_ready, output word held stable while stalled.

module ofdm_bin_slicer #(
    parameter int DATA_W         = 16,
    parameter int NBINS          = 64,
    parameter int BITS_PER_BIN   = 2,
    parameter int FIRST_DATA_BIN = 4,
    parameter int LAST_DATA_BIN  = 55,
    parameter int PILOT0         = 11,
    parameter int PILOT1         = 25,
    parameter int OUT_W          = 32
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  in_valid,
    output logic                                                  in_ready,
    input  logic signed [DATA_W-1:0]                              in_re,
    input  logic signed [DATA_W-1:0]                              in_im,
    input  logic                                                  in_last,
    input  logic [((1 << BITS_PER_BIN) - 1) * (DATA_W + 2) - 1:0] thr,
    output logic                                                  out_valid,
    input  logic                                                  out_ready,
    output logic [OUT_W-1:0]                                      out_data,
    output logic                                                  out_last,
    output logic                                                  sym_done,
    output logic                                                  pilot_ok,
    output logic                                                  len_err
);

    localparam int B     = BITS_PER_BIN;
    localparam int MAG_W = DATA_W + 2;
    localparam int NLEV  = 1 << B;
    localparam int NTHR  = NLEV - 1;
    localparam int BIN_W = $clog2(NBINS);
    localparam int POS_W = $clog2(OUT_W + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [BIN_W-1:0] FIRST_B   = BIN_W'(FIRST_DATA_BIN);
    localparam logic [BIN_W-1:0] LAST_B    = BIN_W'(LAST_DATA_BIN);
    localparam logic [BIN_W-1:0] PIL0_B    = BIN_W'(PILOT0);
    localparam logic [BIN_W-1:0] PIL1_B    = BIN_W'(PILOT1);
    localparam logic [BIN_W-1:0] END_B     = BIN_W'(NBINS - 1);
    localparam logic [BIN_W-1:0] BIN_ONE   = BIN_W'(1);
    localparam logic [POS_W-1:0] POS_STEP  = POS_W'(B);
    localparam logic [POS_W-1:0] POS_FULL  = POS_W'(OUT_W - B);
    localparam logic [MAG_W-1:0] MAG_ONE   = MAG_W'(1);
    localparam logic [B-1:0]     LVL_ONE   = B'(1);
    localparam logic [B-1:0]     LVL_MAX   = '1;

    // Elaboration-time parameter sanity checks
    if (OUT_W % BITS_PER_BIN != 0) begin : g_bad_out_w
        $error("ofdm_bin_slicer: OUT_W must be a multiple of BITS_PER_BIN");
    end
    if (BITS_PER_BIN < 1 || BITS_PER_BIN > 4) begin : g_bad_bits
        $error("ofdm_bin_slicer: BITS_PER_BIN must be 1..4");
    end
    if (NBINS < 8 || NBINS > 1024) begin : g_bad_nbins
        $error("ofdm_bin_slicer: NBINS must be 8..1024");
    end

    // Symbol / packing state
    logic [0:0]       state_q,     state_d;
    logic [BIN_W-1:0] bin_cnt_q,   bin_cnt_d;
    logic [OUT_W-1:0] acc_q,       acc_d;
    logic [POS_W-1:0] pos_q,       pos_d;
    logic             p0_pass_q,   p0_pass_d;
    logic             p1_pass_q,   p1_pass_d;

    // Output registers
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q,  out_data_d;
    logic             out_last_q,  out_last_d;
    logic             sym_done_q,  sym_done_d;
    logic             pilot_ok_q,  pilot_ok_d;
    logic             len_err_q,   len_err_d;

    // Per-sample combinational values
    logic [MAG_W-1:0] re_ext, im_ext, re_abs, im_abs, mag;
    logic [B-1:0]     lvl;
    logic [BIN_W-1:0] cur_bin;
    logic             accept;
    logic             is_data;
    logic             at_end;
    logic             close_sym;
    logic             word_full;
    logic             word_emit;
    logic             p0_now;
    logic             p1_now;
    logic [OUT_W-1:0] acc_ins;

    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign sym_done  = sym_done_q;
    assign pilot_ok  = pilot_ok_q;
    assign len_err   = len_err_q;

    // Two guard bits keep |-2^(DATA_W-1)| + |-2^(DATA_W-1)| exact without saturation
    assign re_ext = {{2{in_re[DATA_W-1]}}, in_re};
    assign im_ext = {{2{in_im[DATA_W-1]}}, in_im};
    assign re_abs = re_ext[MAG_W-1] ? (~re_ext + MAG_ONE) : re_ext;
    assign im_abs = im_ext[MAG_W-1] ? (~im_ext + MAG_ONE) : im_ext;
    assign mag    = re_abs + im_abs;

    // Level = number of thresholds strictly below the magnitude
    always_comb begin
        lvl = '0;
        for (int k = 0; k < NTHR; k++) begin
            if (mag > thr[k*MAG_W +: MAG_W]) begin
                lvl = lvl + LVL_ONE;
            end
        end
    end

    // No symbol open means the next accepted sample is bin 0
    assign cur_bin   = (state_q == ST_IDLE) ? '0 : bin_cnt_q;

    assign is_data   = (cur_bin >= FIRST_B) && (cur_bin <= LAST_B) &&
                       (cur_bin != PIL0_B) && (cur_bin != PIL1_B);
    assign at_end    = (cur_bin == END_B);
    assign close_sym = in_last || at_end;
    assign word_full = is_data && (pos_q == POS_FULL);
    assign word_emit = accept && (word_full || (close_sym && (is_data || (pos_q != '0))));
    assign p0_now    = (cur_bin == PIL0_B) ? (lvl == LVL_MAX) : p0_pass_q;
    assign p1_now    = (cur_bin == PIL1_B) ? (lvl == LVL_MAX) : p1_pass_q;

    // Accumulator with the current level inserted at the next free LSB-first slot
    always_comb begin
        acc_ins = acc_q;
        if (is_data) begin
            acc_ins[pos_q +: B] = lvl;
        end
    end

    // Next-state logic for symbol tracking, packing and the output register
    always_comb begin
        state_d     = state_q;
        bin_cnt_d   = bin_cnt_q;
        acc_d       = acc_q;
        pos_d       = pos_q;
        p0_pass_d   = p0_pass_q;
        p1_pass_d   = p1_pass_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        sym_done_d  = 1'b0;
        pilot_ok_d  = pilot_ok_q;
        len_err_d   = len_err_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        if (accept) begin
            // Output register is free here because in_ready implies it drains this cycle
            if (word_emit) begin
                out_valid_d = 1'b1;
                out_data_d  = acc_ins;
                out_last_d  = close_sym;
            end

            if (close_sym) begin
                state_d    = ST_IDLE;
                bin_cnt_d  = '0;
                acc_d      = '0;
                pos_d      = '0;
                p0_pass_d  = 1'b0;
                p1_pass_d  = 1'b0;
                sym_done_d = 1'b1;
                pilot_ok_d = p0_now && p1_now;
                // Length is wrong when in_last and the final bin disagree
                len_err_d  = in_last ^ at_end;
            end else begin
                state_d   = ST_RUN;
                bin_cnt_d = cur_bin + BIN_ONE;
                p0_pass_d = p0_now;
                p1_pass_d = p1_now;
                if (word_full) begin
                    acc_d = '0;
                    pos_d = '0;
                end else if (is_data) begin
                    acc_d = acc_ins;
                    pos_d = pos_q + POS_STEP;
                end
            end
        end
    end

    // State registers with asynchronous reset that discards any open symbol
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bin_cnt_q   <= '0;
            acc_q       <= '0;
            pos_q       <= '0;
            p0_pass_q   <= 1'b0;
            p1_pass_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            sym_done_q  <= 1'b0;
            pilot_ok_q  <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bin_cnt_q   <= bin_cnt_d;
            acc_q       <= acc_d;
            pos_q       <= pos_d;
            p0_pass_q   <= p0_pass_d;
            p1_pass_q   <= p1_pass_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            sym_done_q  <= sym_done_d;
            pilot_ok_q  <= pilot_ok_d;
            len_err_q   <= len_err_d;
        end
    end

endmodule
